noc_config_filereg_access_unit: RTL and testbench
=================================================

Name: noc_config_filereg_access_unit

Overview:
- Target-side configuration register file for the Configuration virtual network, generalised with parametrised widths and depth.
- Instantiated in the NI next to the router.
- Consumes single-flit request messages (write / read / set-bits / clear-bits) and updates a parametrised register bank that drives the router configuration port.
- Returns response messages (read data, or write acknowledges) through a buffered valid/ready output.

Parameters:
- ModuleAddressSize, 11, width of requester module address.
- CommandFieldSize, 2, command field width.
- RegisterAddressFieldSize, 5, register address field width.
- PayloadFieldSize, 32, register/data width.
- NumberOfRegisters, 16, implemented registers (must be ≤ 2**RegisterAddressFieldSize).
- RespFifoDepth, 2, response buffer entries (≥1).
- WriteAck, 0, 1 = write/set/clear also produce a response.
- ResetValue, 0, reset value of every register (PayloadFieldSize bits).
- Derived:
  - RequestSize = CommandFieldSize + RegisterAddressFieldSize + PayloadFieldSize (39).
  - ResponseSize = ModuleAddressSize + PayloadFieldSize (43).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_data_i  in  RequestSize  {cmd, reg_addr, payload}, cmd at MSBs.
- req_src_i  in  ModuleAddressSize  requester address, sampled with the request.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- resp_data_o  out  ResponseSize  {src_addr, data}, src at MSBs.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- regs_o  out  NumberOfRegisters*PayloadFieldSize  register bank, register k at bits [k*P +: P].
- reg_wr_strobe_o  out  NumberOfRegisters  one-cycle pulse per updated register.
- err_cnt_o  out  8  saturating count of out-of-range accesses.

Behaviour:
- Interface: one clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values:
  - All registers = ResetValue.
  - FIFO empty; resp_valid_o = 0; reg_wr_strobe_o = 0; err_cnt_o = 0.
  - req_ready_o = 0 during the reset cycle, 1 in the first cycle after reset.
- Accept: a request is accepted when req_valid_i && req_ready_o at a rising edge.
- Ready rule: req_ready_o = (fifo_count < RespFifoDepth), combinational from registered count only; no dependence on req_valid_i or resp_ready_i.
- Commands, applied to reg = regs[reg_addr]:
  - 0 WRITE: reg <= payload.
  - 1 READ: no change.
  - 2 SET: reg <= reg | payload.
  - 3 CLEAR: reg <= reg & ~payload.
  - Codes ≥ 4 (if CommandFieldSize > 2) are treated as READ.
- Update latency: register update visible on regs_o one cycle after accept. reg_wr_strobe_o[reg_addr] is high that same cycle for WRITE/SET/CLEAR, even if the value is unchanged.
- Responses:
  - READ always pushes {req_src_i, current reg}, using the pre-update value (no update occurs on READ).
  - If WriteAck = 1, WRITE/SET/CLEAR push {req_src_i, new reg value}.
  - A push at accept makes resp_valid_o = 1 in the next cycle when the FIFO was empty (1-cycle latency).
- Out of range (reg_addr ≥ NumberOfRegisters):
  - No register change, no strobe.
  - err_cnt_o increments, saturating at 255.
  - A response is still pushed when one would be (READ, or writes with WriteAck) with data = all-ones, so requesters never hang.
- Response FIFO:
  - In order, depth RespFifoDepth.
  - resp_data_o / resp_valid_o driven from the head entry and held stable while resp_valid_o && !resp_ready_i.
  - Pop on resp_valid_o && resp_ready_i.
  - Simultaneous push and pop in one cycle is legal at any count; count is unchanged.
- Back-pressure:
  - When full, req_ready_o = 0 for all commands, including non-responding writes; ordering is preserved.
  - Ready returns the cycle after a pop.
- Reset mid-operation: pending FIFO entries are discarded, registers return to ResetValue, and any in-flight accepted request has no effect beyond the reset edge.
- Storage: no combinational path from req_* to resp_* or regs_*; all outputs are registered except req_ready_o.

Test Plan:
- Reset then READ reg 3 from src 0x15 -> resp_data_o = {11'h015, 32'h0} one cycle after accept; err_cnt_o = 0.
- WRITE reg 5 = 0xDEADBEEF, SET reg 5 payload 0x00000010, CLEAR reg 5 payload 0x0000000F, READ reg 5 -> regs_o[5] sequence DEADBEEF, DEADBEFF, DEADBEF0; reg_wr_strobe_o[5] pulses 3 times; read response data 0xDEADBEF0.
- READ reg 20 (NumberOfRegisters=16) from src 0x7FF -> response {11'h7FF, 32'hFFFFFFFF}; err_cnt_o = 1; regs_o unchanged; 300 such reads -> err_cnt_o = 255.
- resp_ready_i = 0, issue 3 READs with RespFifoDepth=2 -> 2 accepted, req_ready_o = 0, resp_data_o stable; raise resp_ready_i -> responses in order, third request accepted the cycle after the first pop.
- WriteAck=1: WRITE reg 0 = 0x1234 from src 0x002 -> response {11'h002, 32'h1234}; with WriteAck=0 the same write produces no response.
- Continuous back-to-back READs with resp_ready_i = 1 -> one accept and one response per cycle, no bubbles; assert rst_i mid-stream -> resp_valid_o = 0 next cycle, registers = ResetValue.

Source files
------------

// File: rtl/noc_config_filereg_access_unit.sv
// Configuration-network register file: single-flit write/read/set/clear requests
// update a parametrised register bank; responses leave through an in-order FIFO.
module noc_config_filereg_access_unit #(
    parameter int ModuleAddressSize        = 11,
    parameter int CommandFieldSize         = 2,
    parameter int RegisterAddressFieldSize = 5,
    parameter int PayloadFieldSize         = 32,
    parameter int NumberOfRegisters        = 16,
    parameter int RespFifoDepth            = 2,
    parameter int WriteAck                 = 0,
    parameter logic [PayloadFieldSize-1:0] ResetValue = '0,
    localparam int RequestSize  = CommandFieldSize + RegisterAddressFieldSize + PayloadFieldSize,
    localparam int ResponseSize = ModuleAddressSize + PayloadFieldSize
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [RequestSize-1:0]                        req_data_i,
    input  logic [ModuleAddressSize-1:0]                  req_src_i,
    input  logic                                          req_valid_i,
    output logic                                          req_ready_o,
    output logic [ResponseSize-1:0]                       resp_data_o,
    output logic                                          resp_valid_o,
    input  logic                                          resp_ready_i,
    output logic [NumberOfRegisters*PayloadFieldSize-1:0] regs_o,
    output logic [NumberOfRegisters-1:0]                  reg_wr_strobe_o,
    output logic [7:0]                                    err_cnt_o
);

    localparam int CmdW     = CommandFieldSize;
    localparam int AddrW    = RegisterAddressFieldSize;
    localparam int P        = PayloadFieldSize;
    localparam int PtrW     = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
    localparam int MemDepth = 1 << PtrW;
    localparam int CntW     = $clog2(RespFifoDepth + 1);

    logic [P-1:0]            r_regs [NumberOfRegisters];
    logic [NumberOfRegisters-1:0] r_wr_strobe;
    logic [7:0]              r_err_cnt;
    logic [ResponseSize-1:0] r_mem [MemDepth];
    logic [PtrW-1:0]         r_wr_ptr;
    logic [PtrW-1:0]         r_rd_ptr;
    logic [CntW-1:0]         r_count;

    logic [CmdW-1:0]         w_cmd;
    logic [AddrW-1:0]        w_addr;
    logic [P-1:0]            w_payload;
    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_modifies;
    logic [P-1:0]            w_cur;
    logic [P-1:0]            w_new;
    logic                    w_push;
    logic                    w_pop;
    logic [ResponseSize-1:0] w_push_data;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_cmd     = req_data_i[RequestSize-1 -: CmdW];
    assign w_addr    = req_data_i[P +: AddrW];
    assign w_payload = req_data_i[P-1:0];

    // Ready is held low while reset is asserted so nothing is accepted in the reset cycle.
    assign req_ready_o  = !rst_i && (r_count < CntW'(RespFifoDepth));
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_in_range   = int'(w_addr) < NumberOfRegisters;
    assign w_pop        = (r_count != '0) && resp_ready_i;
    assign resp_valid_o = (r_count != '0);
    assign resp_data_o  = r_mem[r_rd_ptr];
    assign reg_wr_strobe_o = r_wr_strobe;
    assign err_cnt_o    = r_err_cnt;

    always_comb begin
        w_cur = '0;
        for (int unsigned k = 0; k < NumberOfRegisters; k++) begin
            if (w_addr == AddrW'(k)) w_cur = r_regs[k];
        end
    end

    // Codes outside 0/2/3 behave as READ.
    always_comb begin
        w_new      = w_cur;
        w_modifies = 1'b0;
        if (w_cmd == CmdW'(0)) begin
            w_new      = w_payload;
            w_modifies = 1'b1;
        end else if (w_cmd == CmdW'(2)) begin
            w_new      = w_cur | w_payload;
            w_modifies = 1'b1;
        end else if (w_cmd == CmdW'(3)) begin
            w_new      = w_cur & ~w_payload;
            w_modifies = 1'b1;
        end
    end

    always_comb begin
        w_push      = w_accept && (!w_modifies || (WriteAck != 0));
        w_push_data = {req_src_i, (w_in_range ? w_new : {P{1'b1}})};
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned k = 0; k < NumberOfRegisters; k++) begin
            regs_o[k*P +: P] = r_regs[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NumberOfRegisters; k++) r_regs[k] <= ResetValue;
            r_wr_strobe <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_wr_strobe <= '0;
            if (w_accept && w_modifies && w_in_range) begin
                for (int unsigned k = 0; k < NumberOfRegisters; k++) begin
                    if (w_addr == AddrW'(k)) begin
                        r_regs[k]      <= w_new;
                        r_wr_strobe[k] <= 1'b1;
                    end
                end
            end
            if (w_accept && !w_in_range && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
        end
    end

endmodule

// File: tb/tb_noc_config_filereg_access_unit.sv
// Directed bench for noc_config_filereg_access_unit; a second instance runs with write acknowledges.
module tb_noc_config_filereg_access_unit;

    localparam int P  = 32;
    localparam int N  = 16;
    localparam int A  = 11;
    localparam int RQ = 39;
    localparam int RS = 43;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [RQ-1:0] req_data;
    logic [A-1:0]  req_src;
    logic          req_valid;
    logic          resp_ready;

    logic          req_ready,  b_req_ready;
    logic [RS-1:0] resp_data,  b_resp_data;
    logic          resp_valid, b_resp_valid;
    logic [N*P-1:0] regs,      b_regs;
    logic [N-1:0]  strobe,     b_strobe;
    logic [7:0]    err_cnt,    b_err_cnt;

    int checks = 0;
    int errors = 0;

    noc_config_filereg_access_unit dut (
        .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_src_i(req_src),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .resp_data_o(resp_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .regs_o(regs),
        .reg_wr_strobe_o(strobe), .err_cnt_o(err_cnt)
    );

    noc_config_filereg_access_unit #(.WriteAck(1)) dut_ack (
        .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_src_i(req_src),
        .req_valid_i(req_valid), .req_ready_o(b_req_ready), .resp_data_o(b_resp_data),
        .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready), .regs_o(b_regs),
        .reg_wr_strobe_o(b_strobe), .err_cnt_o(b_err_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int k);
        return regs[k*P +: P];
    endfunction

    // Starts at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [1:0] cmd, input logic [4:0] addr,
                        input logic [31:0] payload, input logic [A-1:0] src);
        req_data  = {cmd, addr, payload};
        req_src   = src;
        req_valid = 1'b1;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        if (!req_ready) check_eq("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_data   = '0;
        req_src    = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("ready_in_reset", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_reset", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_strobe", 64'(strobe), 64'd0);
        check_eq("rst_err", 64'(err_cnt), 64'd0);
        check_eq("rst_regs_or", 64'(|regs), 64'd0);

        // READ reg 3 from 0x15
        send(2'd1, 5'd3, 32'h0, 11'h015);
        check_eq("rd3_valid", 64'(resp_valid), 64'd1);
        check_eq("rd3_data", 64'(resp_data), 64'({11'h015, 32'h0}));
        check_eq("rd3_err", 64'(err_cnt), 64'd0);

        // WRITE / SET / CLEAR / READ on reg 5
        send(2'd0, 5'd5, 32'hDEADBEEF, 11'h001);
        check_eq("wr5_reg", 64'(reg_of(5)), 64'hDEADBEEF);
        check_eq("wr5_strobe", 64'(strobe), 64'h0020);
        check_eq("wr5_no_resp", 64'(resp_valid), 64'd0);
        send(2'd2, 5'd5, 32'h00000010, 11'h001);
        check_eq("set5_reg", 64'(reg_of(5)), 64'hDEADBEFF);
        check_eq("set5_strobe", 64'(strobe), 64'h0020);
        send(2'd3, 5'd5, 32'h0000000F, 11'h001);
        check_eq("clr5_reg", 64'(reg_of(5)), 64'hDEADBEF0);
        check_eq("clr5_strobe", 64'(strobe), 64'h0020);
        send(2'd1, 5'd5, 32'h0, 11'h004);
        check_eq("rd5_data", 64'(resp_data), 64'({11'h004, 32'hDEADBEF0}));
        check_eq("rd5_strobe_low", 64'(strobe), 64'd0);

        // Out-of-range read, then saturate the error counter
        send(2'd1, 5'd20, 32'h0, 11'h7FF);
        check_eq("oor_data", 64'(resp_data), 64'({11'h7FF, 32'hFFFFFFFF}));
        check_eq("oor_valid", 64'(resp_valid), 64'd1);
        check_eq("oor_err1", 64'(err_cnt), 64'd1);
        check_eq("oor_reg5", 64'(reg_of(5)), 64'hDEADBEF0);
        check_eq("oor_strobe", 64'(strobe), 64'd0);
        req_valid = 1'b1;
        repeat (299) @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("oor_err_sat", 64'(err_cnt), 64'd255);
        check_eq("oor_drained", 64'(resp_valid), 64'd0);

        // Back-pressure with depth 2
        resp_ready = 1'b0;
        req_data   = {2'd1, 5'd5, 32'h0};
        req_src    = 11'd1;
        req_valid  = 1'b1;
        @(negedge clk);
        req_src = 11'd2;
        @(negedge clk);
        req_src = 11'd3;
        check_eq("full_ready", 64'(req_ready), 64'd0);
        check_eq("full_valid", 64'(resp_valid), 64'd1);
        check_eq("full_head", 64'(resp_data), 64'({11'd1, 32'hDEADBEF0}));
        repeat (2) @(negedge clk);
        check_eq("stall_head", 64'(resp_data), 64'({11'd1, 32'hDEADBEF0}));
        check_eq("stall_ready", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("ready_after_pop", 64'(req_ready), 64'd1);
        check_eq("order_2", 64'(resp_data), 64'({11'd2, 32'hDEADBEF0}));
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("order_3", 64'(resp_data), 64'({11'd3, 32'hDEADBEF0}));
        check_eq("order_3_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);
        check_eq("bp_drained", 64'(resp_valid), 64'd0);

        // Write acknowledge vs. silent write
        send(2'd0, 5'd0, 32'h00001234, 11'h002);
        check_eq("wa0_no_resp", 64'(resp_valid), 64'd0);
        check_eq("wa0_reg0", 64'(reg_of(0)), 64'h1234);
        check_eq("wa0_strobe", 64'(strobe), 64'h0001);
        check_eq("wa1_valid", 64'(b_resp_valid), 64'd1);
        check_eq("wa1_data", 64'(b_resp_data), 64'({11'h002, 32'h00001234}));

        // Back-to-back reads, then reset mid-stream
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                check_eq("b2b_valid", 64'(resp_valid), 64'd1);
                check_eq("b2b_data", 64'(resp_data), 64'({11'(i + 15), 32'h00001234}));
            end
            check_eq("b2b_ready", 64'(req_ready), 64'd1);
            req_data  = {2'd1, 5'd0, 32'h0};
            req_src   = 11'(i + 16);
            req_valid = 1'b1;
            @(negedge clk);
        end
        check_eq("b2b_last", 64'(resp_data), 64'({11'd23, 32'h00001234}));
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_valid", 64'(resp_valid), 64'd0);
        check_eq("midrst_regs_or", 64'(|regs), 64'd0);
        check_eq("midrst_err", 64'(err_cnt), 64'd0);
        check_eq("midrst_ready", 64'(req_ready), 64'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("midrst_ready_after", 64'(req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
